ahb3lite_dma_tx_port: RTL



---
 rtl/ahb3lite_dma_tx_port_pkg.sv | 24 ++
 rtl/ahb3lite_dma_tx_port_sync_fifo.sv | 47 ++++
 rtl/ahb3lite_dma_tx_port.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ahb3lite_dma_tx_port_pkg.sv
// ahb3lite_dma_tx_pkg: shared AHB encodings, register map, bit positions and response FSM states
// Ports: none (package only).
package ahb3lite_dma_tx_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam int OFF_DATA   = 'h0;
    localparam int OFF_STATUS = 'h4;
    localparam int OFF_CTRL   = 'h8;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_OVF_IE   = 1;
    localparam int CTRL_EMPTY_IE = 2;
    localparam int CTRL_THR_LSB  = 8;
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_LVL_LSB = 8;
    localparam logic [31:0] CTRL_RST = 32'h0000_0100;
    typedef enum logic [1:0] {RSP_IDLE, RSP_ERR1, RSP_ERR2} rsp_state_t;
endpackage

// File: rtl/ahb3lite_dma_tx_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy level; pushes when full and pops when empty are ignored
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data write side,
//        i_pop/o_data read side (o_data is the head entry), o_full, o_empty, o_level.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DW-1:0]              i_data,
    output logic [DW-1:0]              o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/ahb3lite_dma_tx_port.sv
// ahb3lite_dma_tx_port: AHB3-Lite TX endpoint; DMA-written words are queued and drained on a valid/ready stream
// Ports: clk_i, rst_n_i (async active-low); sH* AHB3-Lite slave port (DATA 0x0, STATUS 0x4, CTRL 0x8);
//        tx_data_o/tx_valid_o/tx_ready_i stream; dma_req_o/dma_ack_i DMA request handshake;
//        irq_o only when AHB3LITE_DMA_TX_PORT_IRQ_EN is defined.
module ahb3lite_dma_tx_port
    import ahb3lite_dma_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sHSEL,
    input  logic [31:0] sHADDR,
    input  logic [31:0] sHWDATA,
    output logic [31:0] sHRDATA,
    input  logic        sHWRITE,
    input  logic [2:0]  sHSIZE,
    input  logic [2:0]  sHBURST,
    input  logic [3:0]  sHPROT,
    input  logic [1:0]  sHTRANS,
    input  logic        sHREADY,
    output logic        sHREADYOUT,
    output logic        sHRESP,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        dma_req_o,
    input  logic        dma_ack_i
`ifdef AHB3LITE_DMA_TX_PORT_IRQ_EN
    ,
    output logic        irq_o
`endif
);
`ifdef AHB3LITE_DMA_TX_PORT_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF01;
`endif
    localparam int LW = $clog2(DEPTH) + 1;
    rsp_state_t    r_state;
    logic          r_dp_wr;
    logic          r_dp_rd;
    logic          r_dp_ovf;
    logic [AW-1:0] r_dp_addr;
    logic [31:0]   r_ctrl;
    logic          r_ovf;
    logic          r_dma_req;
    logic          w_accept;
    logic [AW-1:0] w_addr;
    logic          w_size_err;
    logic          w_full_err;
    logic          w_err;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [31:0]   w_level_nxt;
    logic [7:0]    w_lvl8;
    logic [7:0]    w_thr;
    logic [31:0]   w_status;
    logic          w_unused;
    assign w_unused   = ^{sHADDR[31:AW], sHADDR[1:0], sHBURST, sHPROT};
    assign w_accept   = sHSEL & sHREADY & (sHTRANS == HTRANS_NONSEQ || sHTRANS == HTRANS_SEQ);
    assign w_addr     = {sHADDR[AW-1:2], 2'b00};
    assign w_push     = r_dp_wr & (r_dp_addr == AW'(OFF_DATA));
    assign w_pop      = tx_valid_o & tx_ready_i;
    // Level the FIFO will hold during the upcoming data phase; a full FIFO then means the write is dropped
    assign w_level_nxt = 32'(w_level) + 32'(w_push) - 32'(w_pop);
    assign w_size_err = sHSIZE != HSIZE_WORD;
    assign w_full_err = w_accept & ~w_size_err & sHWRITE & (w_addr == AW'(OFF_DATA)) & (w_level_nxt == 32'(DEPTH));
    assign w_err      = w_accept & (w_size_err | w_full_err);
    assign w_lvl8     = (32'(w_level) > 32'd255) ? 8'hFF : 8'(w_level);
    assign w_thr      = (r_ctrl[CTRL_THR_LSB +: 8] == 8'd0) ? 8'd1 : r_ctrl[CTRL_THR_LSB +: 8];
    assign w_status   = {16'h0, w_lvl8, 5'h0, r_ovf, w_full, w_empty};
    assign sHRDATA    = !r_dp_rd ? 32'h0 :
                        (r_dp_addr == AW'(OFF_STATUS)) ? w_status :
                        (r_dp_addr == AW'(OFF_CTRL)) ? r_ctrl : 32'h0;
    assign tx_valid_o = ~w_empty;
    assign dma_req_o  = r_dma_req;
    sync_fifo #(.DEPTH(DEPTH), .DW(32)) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (sHWDATA),
        .o_data  (tx_data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );
    // Errors are decided at the address phase so the first error cycle can be driven from a register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= RSP_IDLE;
            sHREADYOUT <= 1'b1;
            sHRESP     <= HRESP_OKAY;
            r_dp_wr    <= 1'b0;
            r_dp_rd    <= 1'b0;
            r_dp_ovf   <= 1'b0;
            r_dp_addr  <= '0;
        end else if (r_state == RSP_ERR1) begin
            r_state    <= RSP_ERR2;
            sHREADYOUT <= 1'b1;
            sHRESP     <= HRESP_ERROR;
            r_dp_ovf   <= 1'b0;
        end else begin
            r_state    <= w_err ? RSP_ERR1 : RSP_IDLE;
            sHREADYOUT <= ~w_err;
            sHRESP     <= w_err ? HRESP_ERROR : HRESP_OKAY;
            r_dp_wr    <= w_accept & ~w_err & sHWRITE;
            r_dp_rd    <= w_accept & ~w_err & ~sHWRITE;
            r_dp_ovf   <= w_full_err;
            r_dp_addr  <= w_addr;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctrl    <= CTRL_RST;
            r_ovf     <= 1'b0;
            r_dma_req <= 1'b0;
        end else begin
            if (r_dp_wr && r_dp_addr == AW'(OFF_CTRL)) r_ctrl <= sHWDATA & CTRL_MASK;
            if (r_dp_ovf) r_ovf <= 1'b1;
            else if (r_dp_wr && r_dp_addr == AW'(OFF_STATUS) && sHWDATA[STAT_OVF]) r_ovf <= 1'b0;
            // An acknowledged request is held low for one cycle before re-evaluation
            r_dma_req <= (dma_ack_i & r_dma_req) ? 1'b0 :
                         r_ctrl[CTRL_EN] & ((32'(DEPTH) - 32'(w_level)) >= 32'(w_thr));
        end
    end
`ifdef AHB3LITE_DMA_TX_PORT_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) irq_o <= 1'b0;
        else irq_o <= (r_ctrl[CTRL_OVF_IE] & r_ovf) | (r_ctrl[CTRL_EMPTY_IE] & w_empty & r_ctrl[CTRL_EN]);
    end
`endif
endmodule
